// File: rtl/prefetch_queue.sv
// prefetch_queue
//   Instruction fetch front end. Holds the fetch PC, issues sequential reads
//   to a synchronous instruction memory (read data returns one cycle after
//   the request), buffers the returned words tagged with their PC in a
//   DEPTH-entry FIFO, and presents the head entry to decode via valid/ready.
//   A redirect flushes the FIFO and any in-flight read, then restarts fetch
//   at the redirect target.
//
// Ports
//   clk, reset_n          clock, synchronous active-low reset
//   mem_req, mem_addr     read request / address to instruction memory
//   mem_rdata             read data, valid the cycle after mem_req
//   instr_valid/ready     head entry handshake towards decode
//   instr_data, instr_pc  head instruction word and its PC
//   redirect_valid/pc     restart fetch at redirect_pc
//   halt                  block new requests; queue keeps draining
//   occupancy             entries currently held in the FIFO
module prefetch_queue #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int DEPTH   = 4,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int OCC_W  = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_pc,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    input  logic               halt,
    output logic [OCC_W-1:0]   occupancy
);

    logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic               inflight_q, inflight_d;
    logic [ADDR_W-1:0]  inflight_pc_q, inflight_pc_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]   count_q, count_d;

    logic [INSTR_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0]  pc_q   [DEPTH];

    logic               push;
    logic               pop;
    logic               not_empty;
    logic [OCC_W:0]     credit;

    // The in-flight read already owns a slot, so it is counted against
    // DEPTH before another request may be issued.
    assign credit    = {1'b0, count_q} + {{OCC_W{1'b0}}, inflight_q};
    assign not_empty = (count_q != '0);

    assign mem_req     = reset_n && !redirect_valid && !halt &&
                         (credit < (OCC_W + 1)'(DEPTH));
    assign mem_addr    = fetch_pc_q;

    assign push        = inflight_q && !redirect_valid;
    assign instr_valid = reset_n && not_empty && !redirect_valid;
    assign pop         = instr_valid && instr_ready;

    // Storage is not reset, so the head is forced to zero while empty.
    assign instr_data  = not_empty ? data_q[rd_ptr_q] : '0;
    assign instr_pc    = not_empty ? pc_q[rd_ptr_q]   : '0;
    assign occupancy   = count_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = inflight_q;
        inflight_pc_d = inflight_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            inflight_d = 1'b0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            inflight_d = mem_req;
            if (mem_req) begin
                fetch_pc_d    = fetch_pc_q + ADDR_W'(1);
                inflight_pc_d = fetch_pc_q;
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + OCC_W'(1);
                2'b01:   count_d = count_q - OCC_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc_q    <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && push) begin
            data_q[wr_ptr_q] <= mem_rdata;
            pc_q[wr_ptr_q]   <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_prefetch_queue.sv
module tb_prefetch_queue;

    localparam int ADDR_W  = 8;
    localparam int INSTR_W = 16;
    localparam int DEPTH   = 4;
    localparam int OCC_W   = $clog2(DEPTH + 1);

    logic               clk = 1'b0;
    logic               reset_n;
    logic               mem_req;
    logic [ADDR_W-1:0]  mem_addr;
    logic [INSTR_W-1:0] mem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr_data;
    logic [ADDR_W-1:0]  instr_pc;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               halt;
    logic [OCC_W-1:0]   occupancy;

    int tests_run = 0;
    int fails     = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] exp_addr;
    bit                sb_en;

    prefetch_queue #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .occupancy      (occupancy)
    );

    always #5 clk = ~clk;

    function automatic logic [INSTR_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return {~a, a};
    endfunction

    // Synchronous instruction memory with one-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) mem_rdata <= word_of(mem_addr);
    end

    // Scoreboard: issued addresses follow exp_addr; popped entries must match
    // the expected-PC queue the tests fill.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] pc;
        if (sb_en && reset_n) begin
            if (mem_req) begin
                tests_run++;
                if (mem_addr !== exp_addr) begin
                    fails++;
                    $display("FAIL issue_addr: got %h expected %h", mem_addr, exp_addr);
                end
                exp_addr = exp_addr + 8'd1;
            end
            if (instr_valid && instr_ready && exp_q.size() > 0) begin
                pc = exp_q.pop_front();
                tests_run++;
                if (instr_pc !== pc || instr_data !== word_of(pc)) begin
                    fails++;
                    $display("FAIL pop: got pc %h data %h expected pc %h data %h",
                             instr_pc, instr_data, pc, word_of(pc));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sb_en          = 1'b0;
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic release_reset;
        reset_n  = 1'b1;
        exp_addr = '0;
        sb_en    = 1'b1;
        #1;
    endtask

    task automatic push_seq(input logic [ADDR_W-1:0] start, input int n);
        logic [ADDR_W-1:0] a;
        a = start;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a);
            a = a + 8'd1;
        end
    endtask

    task automatic wait_drain(input int bound);
        for (int i = 0; i < bound && exp_q.size() > 0; i++) tick();
    endtask

    task automatic test_reset;
        reset_n        = 1'b0;
        instr_ready    = 1'b1;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 8'h33;
        sb_en          = 1'b0;
        tick();
        tick();
        tests_run++;
        if (mem_req !== 1'b0 || instr_valid !== 1'b0 || occupancy !== 3'd0 ||
            instr_data !== 16'h0 || instr_pc !== 8'h0) begin
            fails++;
            $display("FAIL reset_state: req %b valid %b occ %0d data %h pc %h expected 0 0 0 0000 00",
                     mem_req, instr_valid, occupancy, instr_data, instr_pc);
        end
    endtask

    task automatic test_stream;
        do_reset();
        push_seq(8'h00, 12);
        instr_ready = 1'b1;
        release_reset();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00 || instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_first_req: req %b addr %h valid %b expected 1 00 0",
                     mem_req, mem_addr, instr_valid);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL stream_latency_t1: valid %b expected 0", instr_valid);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            fails++;
            $display("FAIL stream_latency_t2: valid %b pc %h expected 1 00", instr_valid, instr_pc);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            tests_run++;
            if (instr_valid !== 1'b1) begin
                fails++;
                $display("FAIL stream_throughput: cycle %0d valid %b expected 1", i, instr_valid);
            end
        end
        wait_drain(20);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL stream_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_backpressure;
        int nreq;
        do_reset();
        push_seq(8'h00, 10);
        release_reset();
        nreq = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_req) nreq++;
            tick();
        end
        tests_run++;
        if (nreq != DEPTH || occupancy !== 3'd4 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL bp_full: reqs %0d occ %0d req %b expected 4 4 0", nreq, occupancy, mem_req);
        end
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            fails++;
            $display("FAIL bp_head: valid %b pc %h expected 1 00", instr_valid, instr_pc);
        end
        instr_ready = 1'b1;
        wait_drain(40);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL bp_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_redirect;
        do_reset();
        release_reset();
        repeat (4) tick();
        tests_run++;
        if (occupancy !== 3'd3 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_setup: occ %0d req %b expected 3 0", occupancy, mem_req);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 8'h40;
        exp_q.delete();
        push_seq(8'h40, 8);
        exp_addr = 8'h40;
        #1;
        tests_run++;
        if (instr_valid !== 1'b0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL redir_cycle: valid %b req %b expected 0 0", instr_valid, mem_req);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (occupancy !== 3'd0 || mem_req !== 1'b1 || mem_addr !== 8'h40) begin
            fails++;
            $display("FAIL redir_restart: occ %0d req %b addr %h expected 0 1 40",
                     occupancy, mem_req, mem_addr);
        end
        instr_ready = 1'b1;
        tick();
        tests_run++;
        if (instr_valid !== 1'b0) begin
            fails++;
            $display("FAIL redir_r2: valid %b expected 0", instr_valid);
        end
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'h40) begin
            fails++;
            $display("FAIL redir_r3: valid %b pc %h expected 1 40", instr_valid, instr_pc);
        end
        wait_drain(30);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL redir_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_wrap;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 8'hFE;
        release_reset();
        exp_addr = 8'hFE;
        push_seq(8'hFE, 5);
        instr_ready = 1'b1;
        tests_run++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL wrap_redir_cycle: req %b expected 0", mem_req);
        end
        tick();
        redirect_valid = 1'b0;
        #1;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'hFE) begin
            fails++;
            $display("FAIL wrap_first_req: req %b addr %h expected 1 fe", mem_req, mem_addr);
        end
        tick();
        tick();
        tests_run++;
        if (instr_valid !== 1'b1 || instr_pc !== 8'hFE) begin
            fails++;
            $display("FAIL wrap_first_pop: valid %b pc %h expected 1 fe", instr_valid, instr_pc);
        end
        wait_drain(20);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL wrap_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_halt;
        do_reset();
        push_seq(8'h00, 6);
        release_reset();
        tick();
        halt = 1'b1;
        #1;
        tests_run++;
        if (mem_req !== 1'b0) begin
            fails++;
            $display("FAIL halt_block: req %b expected 0", mem_req);
        end
        tick();
        tests_run++;
        if (occupancy !== 3'd1 || instr_valid !== 1'b1 || instr_pc !== 8'h00) begin
            fails++;
            $display("FAIL halt_inflight_pushed: occ %0d valid %b pc %h expected 1 1 00",
                     occupancy, instr_valid, instr_pc);
        end
        repeat (3) tick();
        tests_run++;
        if (mem_req !== 1'b0 || occupancy !== 3'd1) begin
            fails++;
            $display("FAIL halt_hold: req %b occ %0d expected 0 1", mem_req, occupancy);
        end
        halt = 1'b0;
        #1;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h01) begin
            fails++;
            $display("FAIL halt_resume: req %b addr %h expected 1 01", mem_req, mem_addr);
        end
        instr_ready = 1'b1;
        wait_drain(30);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL halt_drain: %0d entries left expected 0", exp_q.size());
        end
        halt           = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 8'h80;
        exp_q.delete();
        push_seq(8'h80, 4);
        exp_addr = 8'h80;
        tick();
        redirect_valid = 1'b0;
        tick();
        tests_run++;
        if (mem_req !== 1'b0 || occupancy !== 3'd0) begin
            fails++;
            $display("FAIL halt_redirect_hold: req %b occ %0d expected 0 0", mem_req, occupancy);
        end
        halt = 1'b0;
        #1;
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h80) begin
            fails++;
            $display("FAIL halt_redirect_pc: req %b addr %h expected 1 80", mem_req, mem_addr);
        end
        wait_drain(20);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL halt_redirect_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        release_reset();
        repeat (3) tick();
        tests_run++;
        if (occupancy !== 3'd2) begin
            fails++;
            $display("FAIL rstmid_setup: occ %0d expected 2", occupancy);
        end
        reset_n = 1'b0;
        sb_en   = 1'b0;
        tick();
        tests_run++;
        if (instr_valid !== 1'b0 || occupancy !== 3'd0 || mem_req !== 1'b0) begin
            fails++;
            $display("FAIL rstmid_clear: valid %b occ %0d req %b expected 0 0 0",
                     instr_valid, occupancy, mem_req);
        end
        exp_q.delete();
        push_seq(8'h00, 4);
        instr_ready = 1'b1;
        release_reset();
        tests_run++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h00) begin
            fails++;
            $display("FAIL rstmid_restart: req %b addr %h expected 1 00", mem_req, mem_addr);
        end
        wait_drain(20);
        tests_run++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL rstmid_drain: %0d entries left expected 0", exp_q.size());
        end
    endtask

    initial begin
        reset_n        = 1'b0;
        instr_ready    = 1'b0;
        halt           = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sb_en          = 1'b0;
        exp_addr       = '0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_wrap();
        test_halt();
        test_reset_mid();
        sb_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
